// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop sync, 3-sample majority vote, 5-8 data bits, optional parity,
// 1/2 stop bits, with a valid/ready frame FIFO carrying per-frame error flags.
package uart_rx_fifo_pkg;
  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_frame_t;
endpackage

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                rx,
  input  logic [DIV_W-1:0]                    baud_div,
  input  logic [1:0]                          data_bits,
  input  logic [1:0]                          parity,
  input  logic                                stop2,
  output logic [7:0]                          rd_data,
  output logic                                rd_perr,
  output logic                                rd_ferr,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level,
  output logic                                overrun,
  input  logic                                clr_overrun
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
  localparam int unsigned HALF  = OVERSAMPLE / 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // rx synchroniser, idles high
  logic rx_meta, rxs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // oversample tick: one cycle every baud_div+1 clocks while enabled
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  assign tick_c = en && (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      div_cnt <= '0;
    else if (!en || div_cnt == '0)   div_cnt <= baud_div;
    else                             div_cnt <= div_cnt - DIV_W'(1);
  end

  state_t          state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic            perr_q, perr_d, ferr_q, ferr_d;
  logic            stop_idx_q, stop_idx_d;
  logic            armed_q, armed_d;
  logic [1:0]      nb_q, nb_d, par_q, par_d;
  logic            stop2_q, stop2_d;
  logic            push_q, push_d;
  rx_frame_t       frame_q, frame_d;

  logic maj_c, decide_c, bit_end_c, par_en_c, ferr_fin_c;
  assign maj_c      = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
  assign decide_c   = (sc_q == SC_W'(HALF + 1));
  assign bit_end_c  = (sc_q == SC_W'(OVERSAMPLE - 1));
  assign par_en_c   = (par_q == 2'b01) || (par_q == 2'b10);
  assign ferr_fin_c = stop_idx_q ? (ferr_q | ~maj_c) : ~maj_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sc_q       <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
      armed_q    <= 1'b1;
      nb_q       <= '0;
      par_q      <= '0;
      stop2_q    <= 1'b0;
      push_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_idx_q <= stop_idx_d;
      armed_q    <= armed_d;
      nb_q       <= nb_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      push_q     <= push_d;
      frame_q    <= frame_d;
    end
  end

  // receive FSM; each state acts only on oversample ticks
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_idx_d = stop_idx_q;
    armed_d    = armed_q;
    nb_d       = nb_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    push_d     = 1'b0;
    frame_d    = frame_q;

    if (!en) begin
      state_d = S_IDLE;
      sc_d    = '0;
      armed_d = 1'b1;
    end else if (tick_c) begin
      if (state_q != S_IDLE) begin
        sc_d = bit_end_c ? '0 : sc_q + SC_W'(1);
        if (sc_q == SC_W'(HALF - 1)) v0_d = rxs;
        if (sc_q == SC_W'(HALF))     v1_d = rxs;
      end
      case (state_q)
        S_IDLE: begin
          if (rxs) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = S_START;
            sc_d       = '0;
            bit_d      = '0;
            shreg_d    = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            stop_idx_d = 1'b0;
            nb_d       = data_bits;
            par_d      = parity;
            stop2_d    = stop2;
          end
        end
        S_START: begin
          if (decide_c && maj_c) begin
            state_d = S_IDLE;
            sc_d    = '0;
          end else if (bit_end_c) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (decide_c) shreg_d[bit_q] = maj_c;
          if (bit_end_c) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd4 + 3'(nb_q)) state_d = par_en_c ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (decide_c) perr_d = ((^shreg_q) ^ maj_c) != par_q[1];
          if (bit_end_c) state_d = S_STOP;
        end
        S_STOP: begin
          if (decide_c) begin
            if (stop2_q && !stop_idx_q && maj_c) begin
              stop_idx_d = 1'b1;
            end else begin
              // leave mid-bit so the next start edge is not missed under clock skew
              push_d  = 1'b1;
              frame_d = '{ferr: ferr_fin_c, perr: perr_q, data: shreg_q};
              armed_d = ~ferr_fin_c;
              state_d = S_IDLE;
              sc_d    = '0;
            end
            ferr_d = ferr_fin_c;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // frame FIFO
  rx_frame_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_d;
  logic             pop_c, full_c, wr_en_c, drop_c;
  rx_frame_t        head_c;

  assign pop_c   = rd_valid && rd_ready;
  assign full_c  = (level == LVL_W'(FIFO_DEPTH));
  assign wr_en_c = push_q && (!full_c || pop_c);
  assign drop_c  = push_q && full_c && !pop_c;
  assign head_c  = mem[rd_ptr];
  assign rd_data = rd_valid ? head_c.data : 8'h00;
  assign rd_perr = rd_valid && head_c.perr;
  assign rd_ferr = rd_valid && head_c.ferr;

  always_comb begin
    level_d = level;
    case ({wr_en_c, pop_c})
      2'b10:   level_d = level + LVL_W'(1);
      2'b01:   level_d = level - LVL_W'(1);
      default: level_d = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
      level    <= level_d;
      rd_valid <= (level_d != '0);
      if (drop_c)           overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame-format vector table plus sequences for
// glitches, break, overrun, coincident push/pop, enable drop and async reset.
module tb_uart_rx_fifo;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int          OS         = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             rx = 1'b1;
  logic [DIV_W-1:0] baud_div = '0;
  logic [1:0]       data_bits = 2'd3;
  logic [1:0]       parity = 2'd0;
  logic             stop2 = 1'b0;
  logic [7:0]       rd_data;
  logic             rd_perr, rd_ferr, rd_valid;
  logic             rd_ready = 1'b0;
  logic [LVL_W-1:0] level;
  logic             overrun;
  logic             clr_overrun = 1'b0;

  uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .OVERSAMPLE(OVERSAMPLE), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx(rx), .baud_div(baud_div),
    .data_bits(data_bits), .parity(parity), .stop2(stop2),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .level(level), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int bc = 16;

  typedef struct {
    logic [7:0] d;
    logic [1:0] db;
    logic [1:0] par;
    logic       st2;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // glitch inverts rx for one tick period centred on sample 8 of the bit
  task automatic send_bit(input logic v, input bit g);
    int t;
    t = bc / OS;
    if (g) begin
      drive(v, t * 9);
      drive(~v, t);
      drive(v, bc - t * 10);
    end else begin
      drive(v, bc);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit hp, input bit pb,
                            input bit s1, input bit hs2, input bit s2, input int gbit);
    int pos;
    pos = 0;
    send_bit(1'b0, pos == gbit); pos++;
    for (int i = 0; i < nb; i++) begin
      send_bit(d[i], pos == gbit); pos++;
    end
    if (hp) begin
      send_bit(pb, pos == gbit); pos++;
    end
    send_bit(s1, pos == gbit); pos++;
    if (hs2) send_bit(s2, pos == gbit);
    rx = 1'b1;
  endtask

  task automatic send_8n1(input logic [7:0] d);
    send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h35, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0};
    vecs[2] = '{8'h35, 2'd2, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0};
    vecs[3] = '{8'h1F, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h2A, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
    vecs[6] = '{8'h35, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1};
    vecs[7] = '{8'h4B, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset level", 32'(level), 0);
    chk("reset overrun", 32'(overrun), 0);
    chk("reset rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    en = 1'b1;
    drive(1'b1, 40);

    // frame-format vectors at 16 clocks/bit
    for (int i = 0; i < 8; i++) begin
      data_bits = vecs[i].db;
      parity = vecs[i].par;
      stop2 = vecs[i].st2;
      send_frame(vecs[i].d, int'(vecs[i].db) + 5, (vecs[i].par == 2'd1) || (vecs[i].par == 2'd2),
                 vecs[i].pbit, vecs[i].s1, vecs[i].st2, vecs[i].s2, -1);
      data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
      drive(1'b1, 2 * bc);
      chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 1);
      chk($sformatf("v%0d level", i), 32'(level), 1);
      chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_d));
      chk($sformatf("v%0d rd_perr", i), 32'(rd_perr), 32'(vecs[i].exp_perr));
      chk($sformatf("v%0d rd_ferr", i), 32'(rd_ferr), 32'(vecs[i].exp_ferr));
      pop_one();
      chk($sformatf("v%0d popped rd_valid", i), 32'(rd_valid), 0);
      chk($sformatf("v%0d popped level", i), 32'(level), 0);
    end

    // 4-clock low glitch is a false start
    drive(1'b0, 4);
    drive(1'b1, 3 * bc);
    chk("short glitch level", 32'(level), 0);

    // 3-clock glitch on sample 8 of data bit 0 at 48 clocks/bit
    baud_div = 16'd2; bc = 48;
    drive(1'b1, 2 * bc);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    drive(1'b1, 2 * bc);
    chk("midbit glitch level", 32'(level), 1);
    chk("midbit glitch data", 32'(rd_data), 32'hA5);
    pop_one();
    baud_div = 16'd0; bc = 16;
    drive(1'b1, 64);

    // 30-bit break: exactly one ferr entry, then normal reception
    drive(1'b0, 30 * bc);
    chk("break level", 32'(level), 1);
    chk("break data", 32'(rd_data), 0);
    chk("break ferr", 32'(rd_ferr), 1);
    drive(1'b1, 2 * bc);
    chk("break still one", 32'(level), 1);
    pop_one();
    send_8n1(8'h5A);
    drive(1'b1, 2 * bc);
    chk("after break data", 32'(rd_data), 32'h5A);
    chk("after break ferr", 32'(rd_ferr), 0);
    pop_one();

    // fill, overrun, clear
    for (int k = 0; k < 8; k++) begin
      send_8n1(8'(k));
      drive(1'b1, bc);
    end
    chk("full level", 32'(level), 8);
    chk("full no overrun", 32'(overrun), 0);
    send_8n1(8'h08);
    drive(1'b1, bc);
    chk("overrun set", 32'(overrun), 1);
    chk("overrun level", 32'(level), 8);
    chk("overrun head", 32'(rd_data), 0);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    chk("overrun cleared", 32'(overrun), 0);

    // pop lands on the push cycle: stop decision at clock 157, push at 158
    fork
      send_8n1(8'h08);
      begin
        repeat (157) @(posedge clk);
        #1;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
      end
    join
    drive(1'b1, bc);
    chk("coincident overrun", 32'(overrun), 0);
    chk("coincident level", 32'(level), 8);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain %0d", k), 32'(rd_data), 32'(k));
      pop_one();
    end
    chk("drained level", 32'(level), 0);
    chk("drained rd_valid", 32'(rd_valid), 0);

    // drop enable mid-frame
    drive(1'b0, bc);
    drive(1'b1, 2 * bc);
    en = 1'b0;
    drive(1'b0, 8);
    drive(1'b1, 8);
    en = 1'b1;
    drive(1'b1, 2 * bc);
    chk("en drop discards", 32'(level), 0);
    send_8n1(8'hC3);
    drive(1'b1, 2 * bc);
    chk("en drop next level", 32'(level), 1);
    chk("en drop next data", 32'(rd_data), 32'hC3);
    pop_one();

    // async reset mid-frame with entries queued
    send_8n1(8'h11); drive(1'b1, bc);
    send_8n1(8'h22); drive(1'b1, bc);
    send_8n1(8'h33); drive(1'b1, bc);
    chk("queued level", 32'(level), 3);
    drive(1'b0, bc);
    drive(1'b1, bc / 2);
    rst_n = 1'b0;
    #1;
    chk("async reset level", 32'(level), 0);
    chk("async reset rd_valid", 32'(rd_valid), 0);
    chk("async reset overrun", 32'(overrun), 0);
    chk("async reset rd_data", 32'(rd_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2 * bc);
    send_8n1(8'h81);
    drive(1'b1, 2 * bc);
    chk("post reset data", 32'(rd_data), 32'h81);
    chk("post reset level", 32'(level), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
